inst_prefetch_buffer: RTL and testbench

Instruction-fetch front end between instruction memory and the pipelined core's IF stage. It issues sequential word fetches ahead of the core and tolerates variable memory latency with in-order responses. Fetched words are held in a small FIFO tagged with their PC. On a redirect (jump, branch or jr resolved in the core) the FIFO is flushed and responses already in flight are discarded.

---
 rtl/inst_prefetch_buffer.sv | 94 +++++++++
 tb/tb_inst_prefetch_buffer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential instruction prefetch into a PC-tagged FIFO with
// redirect flush and stale in-flight response dropping.
module inst_prefetch_buffer #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_b,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_addr,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int QW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [31:0] MAXO_U  = 32'(MAX_OUTSTANDING);
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d, live;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   pq_q [MAX_OUTSTANDING];
  logic          req_fire, resp_fire, stale, push, pop;
  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return (32'(p) == MAXO_U - 32'd1) ? '0 : p + QW'(1);
  endfunction
  assign out_valid     = count_q != '0;
  assign out_inst      = out_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign out_pc        = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign imem_req_addr = fetch_pc_q;
  assign occupancy     = count_q;
  // Credit check counts words already buffered plus live responses still owed.
  always_comb begin
    live           = outst_q - drop_q;
    imem_req_valid = rst_b & ~redirect & ~halt & ((32'(count_q) + 32'(live)) < DEPTH_U) & (32'(outst_q) < MAXO_U);
    req_fire       = imem_req_valid & imem_req_ready;
    resp_fire      = imem_resp_valid & (outst_q != '0);
    stale          = resp_fire & (drop_q != '0);
    push           = resp_fire & ~stale & ~redirect;
    pop            = out_valid & out_ready & ~redirect;
    outst_d        = outst_q + OW'(req_fire) - OW'(resp_fire);
    drop_d         = redirect ? outst_d : drop_q - OW'(stale);
    fetch_pc_d     = redirect ? (redirect_addr & ~32'd3) : fetch_pc_q + (req_fire ? 32'd4 : 32'd0);
    count_d        = redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_ptr_d       = redirect ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d       = redirect ? '0 : wr_ptr_q + AW'(push);
    pq_rd_d        = resp_fire ? qinc(pq_rd_q) : pq_rd_q;
    pq_wr_d        = req_fire ? qinc(pq_wr_q) : pq_wr_q;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pq_rd_q    <= '0;
      pq_wr_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pq_rd_q    <= pq_rd_d;
      pq_wr_q    <= pq_wr_d;
    end
  end
  // Storage needs no reset: occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= pq_q[pq_rd_q];
      fifo_inst_q[wr_ptr_q] <= imem_resp_data;
    end
    if (req_fire) pq_q[pq_wr_q] <= fetch_pc_q;
  end
  assert property (@(posedge clk) disable iff (!rst_b) !(imem_resp_valid && outst_q == '0));
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb_inst_prefetch_buffer: randomized phases against a queue-based model of the prefetcher
// and a latency-randomized in-order memory.
module tb_inst_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0, rst_b = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_resp_data = '0, out_inst, out_pc, redirect_addr = '0;
  logic out_valid, out_ready = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;
  inst_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_b(rst_b), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt), .occupancy(occupancy));
  always #5 clk = ~clk;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } fe_t;
  typedef struct { logic [31:0] addr; int due; } mr_t;
  fl_t inflight[$];
  fe_t fifo[$];
  mr_t mem_q[$];
  logic [31:0] m_pc = RESET_PC;
  int checks = 0, errors = 0, cyc = 0;
  int lat_lo = 1, lat_hi = 1, p_rdy = 100, p_ordy = 100, p_redir = 0, p_halt = 0;
  bit force_redir = 0;
  logic [31:0] force_addr = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int live_cnt();
    int n = 0;
    foreach (inflight[i]) if (!inflight[i].stale) n++;
    return n;
  endfunction
  task automatic set_inputs();
    imem_req_ready = $urandom_range(99) < p_rdy;
    out_ready      = $urandom_range(99) < p_ordy;
    halt           = $urandom_range(99) < p_halt;
    redirect       = force_redir || ($urandom_range(99) < p_redir);
    redirect_addr  = force_redir ? force_addr :
                     ($urandom_range(99) < 25 ? (32'hFFFF_FFE0 | 32'($urandom_range(31))) : 32'($urandom_range(1023)));
    force_redir    = 0;
    imem_resp_valid = mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_resp_data  = imem_resp_valid ? (mem_q[0].addr ^ 32'hFFFF_0000) : $urandom;
  endtask
  task automatic cycle();
    bit er, fire;
    fl_t e;
    @(negedge clk);
    er = !redirect && !halt && (fifo.size() + live_cnt() < DEPTH) && (inflight.size() < MAXO);
    check("req_valid", 32'(imem_req_valid), 32'(er));
    check("req_addr", imem_req_addr, m_pc);
    check("occupancy", 32'(occupancy), fifo.size());
    check("out_valid", 32'(out_valid), 32'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      check("out_pc", out_pc, fifo[0].pc);
      check("out_inst", out_inst, fifo[0].inst);
    end
    fire = er && imem_req_ready;
    e = '{pc: '0, stale: 1'b1};
    if (imem_resp_valid) begin
      e = inflight.pop_front();
      void'(mem_q.pop_front());
    end
    if (redirect) begin
      fifo.delete();
      foreach (inflight[i]) inflight[i].stale = 1;
      m_pc = redirect_addr & ~32'd3;
    end else begin
      if (out_ready && fifo.size() != 0) void'(fifo.pop_front());
      if (imem_resp_valid && !e.stale) fifo.push_back('{pc: e.pc, inst: imem_resp_data});
    end
    if (fire) begin
      inflight.push_back('{pc: m_pc, stale: 1'b0});
      mem_q.push_back('{addr: m_pc, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
      m_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      set_inputs();
      cycle();
    end
  endtask
  task automatic phase(input int lo, input int hi, input int rdy, input int ordy, input int rd, input int hl);
    lat_lo = lo; lat_hi = hi; p_rdy = rdy; p_ordy = ordy; p_redir = rd; p_halt = hl;
  endtask
  task automatic reset_checks();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
  endtask
  initial begin
    #1;
    reset_checks();
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk);
    #1;
    phase(1, 1, 100, 100, 0, 0);
    run(40);
    phase(3, 3, 100, 0, 0, 0);
    run(30);
    p_ordy = 100;
    run(20);
    phase(3, 3, 100, 100, 0, 0);
    run(4);
    force_redir = 1; force_addr = 32'h0000_0100;
    run(20);
    phase(1, 4, 100, 100, 0, 100);
    run(12);
    p_halt = 0;
    run(12);
    phase(1, 4, 70, 70, 8, 15);
    run(400);
    phase(1, 1, 100, 100, 0, 0);
    force_redir = 1; force_addr = 32'hFFFF_FFFF;
    run(20);
    #1 rst_b = 1'b0;
    #1;
    reset_checks();
    m_pc = RESET_PC;
    inflight.delete(); fifo.delete(); mem_q.delete();
    imem_resp_valid = 0; redirect = 0; halt = 0; imem_req_ready = 0;
    @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    phase(1, 4, 80, 60, 6, 10);
    run(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
